tpu_matmul_engine: RTL and testbench
====================================

// Module: tpu_matmul_engine
// PURPOSE
//  Tiled matrix-multiply engine: computes P = A x B (A: m x k, B: k x n) from row-major buffers.
//  Reads A/B words over synchronous-read ports and writes packed P words to a third port.
//  Each word packs LANES elements; lane j occupies bits [16j+15:16j].
//  Sits between the host control regs (m/k/n, base addrs, start) and the global SRAM buffers.
// PARAMETERS
//  ADDR_WIDTH  12   buffer address width (def.v `ADDR_WIDTH)
//  WORD_WIDTH  160  buffer word width = LANES*DATA_WIDTH (def.v `WORD_WIDTH)
//  DATA_WIDTH  16   element width
//  LANES       10   elements per word = output columns computed per tile
// PORTS
//  Clocking: one clock; reset is asynchronous and active-low.
//  clk_i         in   1           clock, all logic on posedge
//  rst_ni        in   1           asynchronous active-low reset
//  start_i       in   1           start request, sampled on posedge while idle/done
//  valid_o       out  1           job complete; held until next accepted start
//  m_i,k_i,n_i   in   ADDR_WIDTH  A rows, A cols = B rows, B cols; sampled at start
//  base_addra_i  in   ADDR_WIDTH  word address of A[0][0]; likewise base_addrb_i, base_addrp_i
//  ena_o,wea_o   out  1           A port enable / write enable (wea_o constant 0)
//  addra_o       out  ADDR_WIDTH  A word address
//  worda_i       in   WORD_WIDTH  A read data, valid the cycle after ena_o
//  enb_o,web_o   out  1           B port enable / write enable (web_o constant 0)
//  addrb_o       out  ADDR_WIDTH  B word address
//  wordb_i       in   WORD_WIDTH  B read data, valid the cycle after enb_o
//  enp_o,wep_o   out  1           P port enable / write enable, pulsed together
//  addrp_o       out  ADDR_WIDTH  P word address
//  wordp_o       out  WORD_WIDTH  P write data
// BEHAVIOUR
//  Layout: WA=ceil(k/LANES), WN=ceil(n/LANES). A[i][c] at base_a+i*WA+c/LANES lane c%LANES;
//   B[r][c] at base_b+r*WN+c/LANES; P[i][c] at base_p+i*WN+c/LANES. Address sums wrap mod 2^ADDR_WIDTH.
//  Reset: state IDLE; valid_o, ena/wea/enb/web/enp/wep = 0; addr*_o = 0; wordp_o = 0; accumulators 0.
//  FSM IDLE -> RUN -> DRAIN -> WRITE -> (RUN next tile | DONE); DONE -> RUN on start.
//  Start accepted in IDLE or DONE: latch m,k,n,bases; clear valid_o; zero tile counters (i=0,t=0).
//   If m, k or n == 0: go straight to DONE (valid_o=1 next cycle), no memory accesses.
//  Tile (row i, column-word t) with steps s=0..k-1, one per cycle in RUN:
//   cycle s: ena_o=enb_o=1, addra_o=base_a+i*WA+s/LANES, addrb_o=base_b+s*WN+t.
//   cycle s+1: a=lane s%LANES of worda_i; acc[j] = (s==0 ? 0 : acc[j]) + a*lane j of wordb_i.
//   RUN->DRAIN after issuing s=k-1; DRAIN performs last MAC with ena/enb=0.
//  WRITE (1 cycle): enp_o=wep_o=1, addrp_o=base_p+i*WN+t, wordp_o lane j = acc[j] if
//   t*LANES+j < n else 0. Next tile: t+1; if t==WN-1 then t=0,i+1; after i==m-1 -> DONE.
//  Tile latency k+2 cycles; total m*WN*(k+2) cycles from start acceptance to DONE.
//  DONE: valid_o=1 held; all enables 0. start_i while RUN/DRAIN/WRITE is ignored.
//  Arithmetic: 16x16 product and accumulation truncated to DATA_WIDTH (mod 2^16); low bits
//   identical for signed/unsigned operands. B lanes beyond n are don't-care (masked on write).
//  Outputs registered; enables/wordp_o are 0 whenever not in the stated cycle.
//  Reset asserted mid-job: immediate return to IDLE with reset values; no further writes.
// TESTING
//  10x10: A[i][j]=(i+1)(j+1), B=2*I, bases 0x000/0x100/0x200 -> P word 0x200+i lane j =
//   2(i+1)(j+1) (row 0: 2,4..20; row 9: 20..200); 10 writes; valid_o after 10*12 cycles.
//  20x20 tiled: A[i][*]=i+1 (2 words/row), B=I -> P words 0x200..0x227 equal A words; 40 writes.
//  n=15,m=1,k=3 with nonzero B garbage in lanes 5..9 of word 1 -> P word 1 lanes 5..9 = 0.
//  Overflow: A=B=[[300]] (1x1) -> P lane0 = 90000 mod 65536 = 24464, other lanes 0.
//  m=0 -> no en pulses, valid_o high one cycle after start; second start clears valid_o.
//  Reset pulse mid-RUN -> all enables 0 immediately, valid_o 0; new start runs cleanly.

Source files
------------

// File: rtl/tpu_matmul_engine.sv
// Tiled matrix-multiply engine: P = A x B from row-major packed word buffers.
// Each tile produces LANES output columns of one P row by streaming k A/B word
// pairs through a one-deep MAC pipeline, then writes the packed result word.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | issuing A/B reads, one reduction step per cycle
// DRAIN | last MAC on the final read data, no new reads
// WRITE | one-cycle P word write of the finished tile
// DONE  | job complete, valid_o held, waiting for start
module tpu_matmul_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 10,
    parameter int WORD_WIDTH = LANES * DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  valid_o,
    input  logic [ADDR_WIDTH-1:0] m_i,
    input  logic [ADDR_WIDTH-1:0] k_i,
    input  logic [ADDR_WIDTH-1:0] n_i,
    input  logic [ADDR_WIDTH-1:0] base_addra_i,
    input  logic [ADDR_WIDTH-1:0] base_addrb_i,
    input  logic [ADDR_WIDTH-1:0] base_addrp_i,
    output logic                  ena_o,
    output logic                  wea_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    input  logic [WORD_WIDTH-1:0] worda_i,
    output logic                  enb_o,
    output logic                  web_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    input  logic [WORD_WIDTH-1:0] wordb_i,
    output logic                  enp_o,
    output logic                  wep_o,
    output logic [ADDR_WIDTH-1:0] addrp_o,
    output logic [WORD_WIDTH-1:0] wordp_o
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

    // column index t*LANES needs headroom beyond ADDR_WIDTH for the lane mask compare
    localparam int CW = ADDR_WIDTH + 4;
    localparam int LW = $clog2(LANES);
    typedef logic [ADDR_WIDTH:0] ext_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] m_r, k_r, n_r, wa_r, wn_r, base_b_r;
    logic [ADDR_WIDTH-1:0] a_row_r, b_tile_r, p_addr_r;
    logic [ADDR_WIDTH-1:0] s_cnt, t_cnt, i_cnt;
    logic [CW-1:0]         col_r;
    logic [LW-1:0]         lane_a, mac_lane;
    logic                  mac_vld, mac_first;
    logic [DATA_WIDTH-1:0] acc     [LANES];
    logic [DATA_WIDTH-1:0] acc_nxt [LANES];
    logic [DATA_WIDTH-1:0] a_elem;
    logic [WORD_WIDTH-1:0] wordp_nxt;
    logic [ADDR_WIDTH-1:0] wa_nxt, wn_nxt;
    logic                  zero_job, s_last, t_last, tile_last;

    assign wea_o = 1'b0;
    assign web_o = 1'b0;

    assign zero_job  = (m_i == '0) || (k_i == '0) || (n_i == '0);
    assign wa_nxt    = ADDR_WIDTH'((ext_t'(k_i) + ext_t'(LANES - 1)) / ext_t'(LANES));
    assign wn_nxt    = ADDR_WIDTH'((ext_t'(n_i) + ext_t'(LANES - 1)) / ext_t'(LANES));
    assign s_last    = (s_cnt == k_r - 1'b1);
    assign t_last    = (t_cnt == wn_r - 1'b1);
    assign tile_last = t_last && (i_cnt == m_r - 1'b1);

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start_i) state_nxt = zero_job ? S_DONE : S_RUN;
            S_RUN:          if (s_last) state_nxt = S_DRAIN;
            S_DRAIN:        state_nxt = S_WRITE;
            S_WRITE:        state_nxt = tile_last ? S_DONE : S_RUN;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // MAC on the read data returned this cycle, plus the masked write word
    always_comb begin
        a_elem    = worda_i[DATA_WIDTH*mac_lane +: DATA_WIDTH];
        wordp_nxt = '0;
        for (int j = 0; j < LANES; j++) begin
            acc_nxt[j] = acc[j];
            if (mac_vld)
                acc_nxt[j] = (mac_first ? '0 : acc[j]) + a_elem * wordb_i[j*DATA_WIDTH +: DATA_WIDTH];
            if ((col_r + CW'(j)) < CW'(n_r))
                wordp_nxt[j*DATA_WIDTH +: DATA_WIDTH] = acc_nxt[j];
        end
    end

    // datapath, address generation and registered port outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            ena_o     <= 1'b0;
            enb_o     <= 1'b0;
            enp_o     <= 1'b0;
            wep_o     <= 1'b0;
            addra_o   <= '0;
            addrb_o   <= '0;
            addrp_o   <= '0;
            wordp_o   <= '0;
            m_r       <= '0;
            k_r       <= '0;
            n_r       <= '0;
            wa_r      <= '0;
            wn_r      <= '0;
            base_b_r  <= '0;
            a_row_r   <= '0;
            b_tile_r  <= '0;
            p_addr_r  <= '0;
            s_cnt     <= '0;
            t_cnt     <= '0;
            i_cnt     <= '0;
            col_r     <= '0;
            lane_a    <= '0;
            mac_lane  <= '0;
            mac_vld   <= 1'b0;
            mac_first <= 1'b0;
            for (int j = 0; j < LANES; j++) acc[j] <= '0;
        end else begin
            mac_vld   <= ena_o;
            mac_first <= (s_cnt == '0);
            mac_lane  <= lane_a;
            for (int j = 0; j < LANES; j++) acc[j] <= acc_nxt[j];
            ena_o   <= 1'b0;
            enb_o   <= 1'b0;
            enp_o   <= 1'b0;
            wep_o   <= 1'b0;
            wordp_o <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        valid_o  <= zero_job;
                        m_r      <= m_i;
                        k_r      <= k_i;
                        n_r      <= n_i;
                        wa_r     <= wa_nxt;
                        wn_r     <= wn_nxt;
                        base_b_r <= base_addrb_i;
                        a_row_r  <= base_addra_i;
                        b_tile_r <= base_addrb_i;
                        p_addr_r <= base_addrp_i;
                        s_cnt    <= '0;
                        t_cnt    <= '0;
                        i_cnt    <= '0;
                        col_r    <= '0;
                        lane_a   <= '0;
                        if (!zero_job) begin
                            ena_o   <= 1'b1;
                            enb_o   <= 1'b1;
                            addra_o <= base_addra_i;
                            addrb_o <= base_addrb_i;
                        end
                    end
                end
                S_RUN: begin
                    if (!s_last) begin
                        ena_o   <= 1'b1;
                        enb_o   <= 1'b1;
                        s_cnt   <= s_cnt + 1'b1;
                        addrb_o <= addrb_o + wn_r;
                        if (lane_a == LW'(LANES - 1)) begin
                            lane_a  <= '0;
                            addra_o <= addra_o + 1'b1;
                        end else begin
                            lane_a <= lane_a + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    enp_o   <= 1'b1;
                    wep_o   <= 1'b1;
                    addrp_o <= p_addr_r;
                    wordp_o <= wordp_nxt;
                end
                S_WRITE: begin
                    if (tile_last) begin
                        valid_o <= 1'b1;
                    end else begin
                        ena_o    <= 1'b1;
                        enb_o    <= 1'b1;
                        s_cnt    <= '0;
                        lane_a   <= '0;
                        p_addr_r <= p_addr_r + 1'b1;
                        if (t_last) begin
                            t_cnt    <= '0;
                            col_r    <= '0;
                            i_cnt    <= i_cnt + 1'b1;
                            a_row_r  <= a_row_r + wa_r;
                            addra_o  <= a_row_r + wa_r;
                            b_tile_r <= base_b_r;
                            addrb_o  <= base_b_r;
                        end else begin
                            t_cnt    <= t_cnt + 1'b1;
                            col_r    <= col_r + CW'(LANES);
                            addra_o  <= a_row_r;
                            b_tile_r <= b_tile_r + 1'b1;
                            addrb_o  <= b_tile_r + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_matmul_engine.sv
// Bench for tpu_matmul_engine: behavioural SRAM model, element-level reference
// matmul feeding a queue of expected P writes, table of jobs plus reset corners.
module tb_tpu_matmul_engine;
    localparam int AW = 12;
    localparam int WW = 160;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] m = '0, k = '0, n = '0;
    logic [AW-1:0] ba = 12'h000, bb = 12'h100, bp = 12'h200;
    logic          valid, ena, wea, enb, web, enp, wep;
    logic [AW-1:0] addra, addrb, addrp;
    logic [WW-1:0] worda = '0, wordb = '0, wordp;

    tpu_matmul_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_o(valid),
        .m_i(m), .k_i(k), .n_i(n),
        .base_addra_i(ba), .base_addrb_i(bb), .base_addrp_i(bp),
        .ena_o(ena), .wea_o(wea), .addra_o(addra), .worda_i(worda),
        .enb_o(enb), .web_o(web), .addrb_o(addrb), .wordb_i(wordb),
        .enp_o(enp), .wep_o(wep), .addrp_o(addrp), .wordp_o(wordp)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] mem [4096];

    always @(posedge clk) begin
        if (ena) worda <= mem[addra];
        if (enb) wordb <= mem[addrb];
    end

    typedef struct { logic [AW-1:0] addr; logic [WW-1:0] word; } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;

    typedef struct { int mm; int kk; int nn; int pat; } case_t;
    case_t cases [5];

    logic [15:0] a_el [20][20];
    logic [15:0] b_el [20][20];

    int total = 0, bad = 0;
    int wr_cnt = 0, en_cnt = 0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // scoreboard: every P write is popped and compared against the reference
    always @(negedge clk) begin
        if (rst_n) begin
            if (ena || enb || enp) en_cnt++;
            if (wea || web) chk("read_port_we", {wea, web}, 2'b00);
            if (enp) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", addrp, '1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("p_addr", addrp, mon_e.addr);
                    chk("p_word", wordp, mon_e.word);
                    chk("p_wep", wep, 1'b1);
                end
            end
        end
    end

    // fill buffers with garbage, place A/B elements, queue the reference P words
    task automatic load(input int pat, input int mm, input int kk, input int nn);
        int wa, wn;
        logic [AW-1:0] ad;
        logic [WW-1:0] w;
        logic [15:0] sum;
        wa = (kk + L - 1) / L;
        wn = (nn + L - 1) / L;
        for (int x = 0; x < 4096; x++)
            mem[x] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 20; j++) begin
                case (pat)
                    0: begin a_el[i][j] = 16'((i + 1) * (j + 1)); b_el[i][j] = (i == j) ? 16'd2 : 16'd0; end
                    1: begin a_el[i][j] = 16'(i + 1); b_el[i][j] = (i == j) ? 16'd1 : 16'd0; end
                    3: begin a_el[i][j] = 16'd300; b_el[i][j] = 16'd300; end
                    default: begin a_el[i][j] = 16'($urandom()); b_el[i][j] = 16'($urandom()); end
                endcase
            end
        end
        for (int i = 0; i < mm; i++)
            for (int c = 0; c < kk; c++) begin
                ad = ba + AW'(i * wa + c / L);
                mem[ad][(c % L)*16 +: 16] = a_el[i][c];
            end
        for (int r = 0; r < kk; r++)
            for (int c = 0; c < nn; c++) begin
                ad = bb + AW'(r * wn + c / L);
                mem[ad][(c % L)*16 +: 16] = b_el[r][c];
            end
        for (int i = 0; i < mm; i++)
            for (int t = 0; t < wn; t++) begin
                w = '0;
                for (int j = 0; j < L; j++) begin
                    if (t * L + j < nn) begin
                        sum = '0;
                        for (int r = 0; r < kk; r++) sum = sum + a_el[i][r] * b_el[r][t*L+j];
                        w[j*16 +: 16] = sum;
                    end
                end
                exp_q.push_back('{addr: bp + AW'(i * wn + t), word: w});
            end
    endtask

    task automatic run_job(input int mm, input int kk, input int nn, input int exp_cyc, input int exp_wr);
        int cyc;
        m = AW'(mm); k = AW'(kk); n = AW'(nn);
        wr_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("valid_cleared", valid, 1'b0);
        cyc = 0;
        while (!valid && cyc < exp_cyc + 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("job_cycles", cyc, exp_cyc);
        chk("write_count", wr_cnt, exp_wr);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int wn;
        cases[0] = '{mm: 10, kk: 10, nn: 10, pat: 0};
        cases[1] = '{mm: 20, kk: 20, nn: 20, pat: 1};
        cases[2] = '{mm: 1,  kk: 3,  nn: 15, pat: 2};
        cases[3] = '{mm: 1,  kk: 1,  nn: 1,  pat: 3};
        cases[4] = '{mm: 3,  kk: 12, nn: 7,  pat: 4};

        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_en", {ena, wea, enb, web, enp, wep}, 6'b0);
        chk("rst_addr", {addra, addrb, addrp}, 36'b0);
        chk("rst_wordp", wordp, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // empty job: straight to DONE, no memory traffic
        m = '0; k = 12'd5; n = 12'd5;
        en_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("zero_valid", valid, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_no_access", en_cnt, 0);

        foreach (cases[c]) begin
            wn = (cases[c].nn + L - 1) / L;
            load(cases[c].pat, cases[c].mm, cases[c].kk, cases[c].nn);
            run_job(cases[c].mm, cases[c].kk, cases[c].nn,
                    cases[c].mm * wn * (cases[c].kk + 2), cases[c].mm * wn);
        end

        // reset in the middle of a run
        load(0, 10, 10, 10);
        m = 12'd10; k = 12'd10; n = 12'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_en", {ena, enb, enp, wep}, 4'b0);
        chk("midrst_valid", valid, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_idle_valid", valid, 1'b0);
        load(3, 1, 1, 1);
        run_job(1, 1, 1, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
